dcache_miss_ctrl: RTL and testbench

- Miss sequencer for the fully-associative data cache.
- Watches the core's data-memory access and the cache's hit/victim status.
- On a miss it stalls the core, writes back a modified victim line if needed, refills the missing line from the backing data memory over a req/ack port, then pulses the cache fill strobe and releases the stall.
- Also keeps hit/miss statistics and a sticky timeout flag for the memory port.

---
 rtl/dcache_miss_ctrl_pkg.sv | 15 +
 rtl/dcache_miss_ctrl_sat_counter.sv | 21 ++
 rtl/dcache_miss_ctrl.sv | 114 +++++++++++
 tb/tb_dcache_miss_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_miss_ctrl_pkg.sv
// rtl/dcache_miss_ctrl_pkg.sv - shared state encoding and address geometry for the dcache miss path
package dcache_miss_ctrl_pkg;

  localparam int ADDR_W_DEF         = 14;
  localparam int LINE_BYTES_LOG_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB   = 3'd1,
    ST_RD   = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } miss_state_t;

endpackage

// File: rtl/dcache_miss_ctrl_sat_counter.sv
// rtl/dcache_miss_ctrl_sat_counter.sv - saturating statistics counter with async active-low clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - miss sequencer: stall, optional victim write-back, line refill, fill strobe
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LINE_BYTES_LOG = LINE_BYTES_LOG_DEF,
  parameter int TIMEOUT        = 255,
  parameter int CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         memread,
  input  logic                         memwrite,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         hit,
  input  logic                         victim_modified,
  input  logic [ADDR_W-LINE_BYTES_LOG-1:0] victim_line_addr,
  output logic                         clk_stall,
  output logic [ADDR_W-1:0]            addr_buf,
  output logic                         memread_buf,
  output logic                         memwrite_buf,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-LINE_BYTES_LOG-1:0] mem_line_addr,
  input  logic                         mem_ack,
  output logic                         fill_en,
  output logic                         timeout_err,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  miss_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              access;
  logic              hit_inc;
  logic              miss_inc;

  assign access   = memread | memwrite;
  assign hit_inc  = (state == ST_IDLE) & access & hit;
  assign miss_inc = (state == ST_IDLE) & access & ~hit;

  assign clk_stall = (state != ST_IDLE);
  assign mem_req   = (state == ST_WB) || (state == ST_RD);
  assign mem_we    = (state == ST_WB);
  assign fill_en   = (state == ST_FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr_buf      <= '0;
      memread_buf   <= 1'b0;
      memwrite_buf  <= 1'b0;
      mem_line_addr <= '0;
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access && !hit) begin
            addr_buf     <= addr;
            memread_buf  <= memread;
            memwrite_buf <= memwrite;
            wait_cnt     <= '0;
            if (victim_modified) begin
              state         <= ST_WB;
              mem_line_addr <= victim_line_addr;
            end else begin
              state         <= ST_RD;
              mem_line_addr <= addr[ADDR_W-1:LINE_BYTES_LOG];
            end
          end
        end
        ST_WB, ST_RD: begin
          // An ack arriving on the last allowed cycle still completes the transfer.
          if (mem_ack) begin
            if (state == ST_WB) begin
              state         <= ST_RD;
              mem_line_addr <= addr_buf[ADDR_W-1:LINE_BYTES_LOG];
              wait_cnt      <= '0;
            end else begin
              state <= ST_FILL;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        ST_FILL: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .cnt   (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .cnt   (miss_cnt)
  );

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - directed self-checking bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite, hit, victim_modified, mem_ack;
  logic [13:0] addr;
  logic [11:0] victim_line_addr;
  logic        clk_stall, memread_buf, memwrite_buf, mem_req, mem_we, fill_en, timeout_err;
  logic [13:0] addr_buf;
  logic [11:0] mem_line_addr;
  logic [15:0] hit_cnt, miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .memread          (memread),
    .memwrite         (memwrite),
    .addr             (addr),
    .hit              (hit),
    .victim_modified  (victim_modified),
    .victim_line_addr (victim_line_addr),
    .clk_stall        (clk_stall),
    .addr_buf         (addr_buf),
    .memread_buf      (memread_buf),
    .memwrite_buf     (memwrite_buf),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_line_addr    (mem_line_addr),
    .mem_ack          (mem_ack),
    .fill_en          (fill_en),
    .timeout_err      (timeout_err),
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memread = 0; memwrite = 0; hit = 0; victim_modified = 0;
    mem_ack = 0; addr = '0; victim_line_addr = '0;
    #1;
    vectors++;
    if ({clk_stall, mem_req, mem_we, fill_en, timeout_err, memread_buf, memwrite_buf} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {clk_stall, mem_req, mem_we, fill_en, timeout_err, memread_buf, memwrite_buf});
    end
    vectors++;
    if (addr_buf !== 14'h0 || mem_line_addr !== 12'h0 || hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got addr_buf=%h line=%h hit=%h miss=%h expected all 0",
               addr_buf, mem_line_addr, hit_cnt, miss_cnt);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_hits();
    int stalls = 0;
    memread = 1; hit = 1; addr = 14'h0040;
    for (int i = 0; i < 5; i++) begin
      step();
      if (clk_stall) stalls++;
    end
    memread = 0;
    step();
    vectors++;
    if (stalls !== 0) begin
      miscompares++;
      $display("FAIL hit_stall: got %0d stalled cycles expected 0", stalls);
    end
    vectors++;
    if (hit_cnt !== 16'd5 || miss_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL hit_count: got hit=%0d miss=%0d expected hit=5 miss=0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_clean_miss();
    int stalls = 0;
    int fills = 0;
    memread = 1; hit = 0; victim_modified = 0; addr = 14'h1234;
    step();
    memread = 0;
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_line_addr !== 12'h48D) begin
      miscompares++;
      $display("FAIL clean_rd: got req=%b we=%b line=%h expected req=1 we=0 line=48d",
               mem_req, mem_we, mem_line_addr);
    end
    vectors++;
    if (addr_buf !== 14'h1234 || memread_buf !== 1'b1 || memwrite_buf !== 1'b0 || miss_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL clean_latch: got addr_buf=%h rd=%b wr=%b miss=%0d expected 1234 1 0 1",
               addr_buf, memread_buf, memwrite_buf, miss_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      if (clk_stall) stalls++;
      if (fill_en) fills++;
      mem_ack = mem_req;
      step();
      mem_ack = 0;
    end
    vectors++;
    if (stalls !== 3 || fills !== 1) begin
      miscompares++;
      $display("FAIL clean_timing: got stall=%0d fill=%0d expected stall=3 fill=1", stalls, fills);
    end
    vectors++;
    if (hit_cnt !== 16'd5 || miss_cnt !== 16'd1 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_counts: got hit=%0d miss=%0d to=%b expected 5 1 0", hit_cnt, miss_cnt, timeout_err);
    end
  endtask

  task automatic test_dirty_miss();
    int stalls = 0;
    int fills = 0;
    memwrite = 1; hit = 0; victim_modified = 1; addr = 14'h1010; victim_line_addr = 12'h7FF;
    step();
    memwrite = 0; victim_modified = 0;
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_line_addr !== 12'h7FF || memwrite_buf !== 1'b1 || memread_buf !== 1'b0) begin
      miscompares++;
      $display("FAIL dirty_wb: got req=%b we=%b line=%h wbuf=%b rbuf=%b expected 1 1 7ff 1 0",
               mem_req, mem_we, mem_line_addr, memwrite_buf, memread_buf);
    end
    step(); step();
    vectors++;
    if (mem_we !== 1'b1 || mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL dirty_wb_hold: got req=%b we=%b expected 1 1", mem_req, mem_we);
    end
    mem_ack = 1;
    step();
    mem_ack = 0;
    vectors++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_line_addr !== 12'h404) begin
      miscompares++;
      $display("FAIL dirty_rd: got req=%b we=%b line=%h expected 1 0 404", mem_req, mem_we, mem_line_addr);
    end
    for (int i = 0; i < 10; i++) begin
      if (clk_stall) stalls++;
      if (fill_en) fills++;
      mem_ack = (i == 2);
      step();
      mem_ack = 0;
    end
    vectors++;
    if (stalls !== 5 || fills !== 1 || clk_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL dirty_tail: got stall=%0d fill=%0d stall_now=%b expected 5 1 0", stalls, fills, clk_stall);
    end
    vectors++;
    if (miss_cnt !== 16'd2 || hit_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL dirty_counts: got hit=%0d miss=%0d expected 5 2", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_timeout();
    int rd_cycles = 0;
    int fills = 0;
    memread = 1; hit = 0; victim_modified = 0; addr = 14'h0200;
    step();
    memread = 0;
    for (int i = 0; i < 400 && mem_req; i++) begin
      rd_cycles++;
      if (fill_en) fills++;
      if (rd_cycles == 254 && timeout_err !== 1'b0) fills += 100;
      step();
    end
    vectors++;
    if (rd_cycles !== 255) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d RD cycles expected 255", rd_cycles);
    end
    vectors++;
    if (timeout_err !== 1'b1 || clk_stall !== 1'b1 || fill_en !== 1'b0 || fills !== 0) begin
      miscompares++;
      $display("FAIL timeout_done: got to=%b stall=%b fill=%b early=%0d expected 1 1 0 0",
               timeout_err, clk_stall, fill_en, fills);
    end
    step();
    vectors++;
    if (clk_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_idle: got stall=%b expected 0", clk_stall);
    end
    memread = 1; hit = 1;
    step(); step();
    memread = 0;
    vectors++;
    if (timeout_err !== 1'b1 || hit_cnt !== 16'd7 || miss_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL timeout_sticky: got to=%b hit=%0d miss=%0d expected 1 7 3", timeout_err, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid_rd();
    int fills = 0;
    memread = 1; hit = 0; victim_modified = 0; addr = 14'h0100;
    step();
    memread = 0;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midrd_req: got req=%b expected 1", mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, clk_stall, fill_en, mem_we, timeout_err, memread_buf} !== 6'b0 ||
        hit_cnt !== 16'h0 || miss_cnt !== 16'h0 || addr_buf !== 14'h0 || mem_line_addr !== 12'h0) begin
      miscompares++;
      $display("FAIL midrd_async: got req=%b stall=%b fill=%b to=%b hit=%h miss=%h abuf=%h expected all 0",
               mem_req, clk_stall, fill_en, timeout_err, hit_cnt, miss_cnt, addr_buf);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1;
      step();
      if (fill_en || clk_stall) fills++;
    end
    mem_ack = 0;
    vectors++;
    if (fills !== 0) begin
      miscompares++;
      $display("FAIL midrd_abandon: got %0d fill/stall cycles expected 0", fills);
    end
  endtask

  task automatic test_saturation();
    memread = 1; hit = 1; addr = 14'h0080;
    for (int i = 0; i < 65534; i++) step();
    vectors++;
    if (hit_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_pre: got hit=%h expected fffe", hit_cnt);
    end
    step(); step();
    vectors++;
    if (hit_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_reach: got hit=%h expected ffff", hit_cnt);
    end
    step(); step(); step();
    memread = 0;
    vectors++;
    if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'h0 || clk_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_hold: got hit=%h miss=%h stall=%b expected ffff 0 0", hit_cnt, miss_cnt, clk_stall);
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_clean_miss();
    test_dirty_miss();
    test_timeout();
    test_reset_mid_rd();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
